// File: rtl/seg_capture_pkg.sv
// Shared constants, FSM state type and helpers for the seven-segment frame capture.
package seg_capture_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;

  // Active-low segment codes, bit6=g ... bit0=a
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;

  localparam logic [BCD_W-1:0] BCD_INVALID = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_e;

  // True when exactly one active-low digit enable is asserted.
  function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
    logic [NUM_DIGITS-1:0] n;
    n = ~an;
    return (n != '0) && ((n & (n - NUM_DIGITS'(1))) == '0);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low seven-segment pattern into a BCD numeral.
module seg7_to_bcd
  import seg_capture_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             invalid_o
);

  always_comb begin
    bcd_o     = BCD_INVALID;
    invalid_o = 1'b0;
    case (pattern_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_display_capture.sv
// Captures a multiplexed 4-digit seven-segment scan into a BCD frame once every
// digit has been seen stable; partial frames are dropped after a timeout.
module seg_display_capture
  import seg_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SEG_W-1:0]              seg,
  input  logic [NUM_DIGITS-1:0]         an,
  output logic [NUM_DIGITS*BCD_W-1:0]   bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_err,
  output logic                          frame_valid,
  output logic                          frame_timeout
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SAMPLE_W = NUM_DIGITS + SEG_W;
  localparam int unsigned FRAME_W  = NUM_DIGITS * BCD_W;

  logic [SEG_W-1:0]      seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;
  logic [SAMPLE_W-1:0]   prev_q;
  logic [CNT_W-1:0]      stab_q, stab_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [FRAME_W-1:0]    shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0] shadow_err_q, shadow_err_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [FRAME_W-1:0]    bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] err_q, err_d;
  logic                  fv_q, fv_d;
  logic                  ft_q, ft_d;
  state_e                state_q, state_d;

  logic [SAMPLE_W-1:0]   cur_c;
  logic                  eligible_c, same_c, capture_c;
  logic [NUM_DIGITS-1:0] cap_bit_c;
  logic [BCD_W-1:0]      dec_bcd;
  logic                  dec_inv;

  seg7_to_bcd u_dec (
    .pattern_i (seg_s2_q),
    .bcd_o     (dec_bcd),
    .invalid_o (dec_inv)
  );

  assign cur_c      = {an_s2_q, seg_s2_q};
  assign eligible_c = one_low(an_s2_q);
  assign same_c     = (cur_c == prev_q);
  assign capture_c  = eligible_c && same_c && (stab_q == CNT_W'(STABLE_CYCLES - 1));
  assign cap_bit_c  = capture_c ? ~an_s2_q : '0;

  // Stability counter saturates at STABLE_CYCLES so each window captures once.
  always_comb begin
    stab_d = stab_q;
    if (!eligible_c) begin
      stab_d = '0;
    end else if (!same_c) begin
      stab_d = CNT_W'(1);
    end else if (stab_q != CNT_W'(STABLE_CYCLES)) begin
      stab_d = stab_q + CNT_W'(1);
    end
  end

  // Shadow slot write, then frame assembly and timeout FSM.
  always_comb begin
    shadow_bcd_d = shadow_bcd_q;
    shadow_err_d = shadow_err_q;
    state_d      = state_q;
    mask_d       = mask_q;
    to_d         = to_q;
    bcd_d        = bcd_q;
    err_d        = err_q;
    fv_d         = 1'b0;
    ft_d         = 1'b0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_bit_c[i]) begin
        shadow_bcd_d[BCD_W*i +: BCD_W] = dec_bcd;
        shadow_err_d[i]                = dec_inv;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (capture_c) begin
          state_d = ST_COLLECT;
          mask_d  = cap_bit_c;
          to_d    = '0;
        end
      end
      ST_COLLECT: begin
        if (mask_q == '1) begin
          bcd_d   = shadow_bcd_q;
          err_d   = shadow_err_q;
          fv_d    = 1'b1;
          mask_d  = cap_bit_c;
          to_d    = '0;
          state_d = capture_c ? ST_COLLECT : ST_IDLE;
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          ft_d    = 1'b1;
          mask_d  = cap_bit_c;
          to_d    = '0;
          state_d = capture_c ? ST_COLLECT : ST_IDLE;
        end else begin
          mask_d = mask_q | cap_bit_c;
          to_d   = to_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q     <= '1;
      seg_s2_q     <= '1;
      an_s1_q      <= '1;
      an_s2_q      <= '1;
      prev_q       <= '1;
      stab_q       <= '0;
      to_q         <= '0;
      shadow_bcd_q <= '0;
      shadow_err_q <= '0;
      mask_q       <= '0;
      bcd_q        <= '0;
      err_q        <= '0;
      fv_q         <= 1'b0;
      ft_q         <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      seg_s1_q     <= seg;
      seg_s2_q     <= seg_s1_q;
      an_s1_q      <= an;
      an_s2_q      <= an_s1_q;
      prev_q       <= cur_c;
      stab_q       <= stab_d;
      to_q         <= to_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_err_q <= shadow_err_d;
      mask_q       <= mask_d;
      bcd_q        <= bcd_d;
      err_q        <= err_d;
      fv_q         <= fv_d;
      ft_q         <= ft_d;
      state_q      <= state_d;
    end
  end

  assign bcd_out       = bcd_q;
  assign digit_err     = err_q;
  assign frame_valid   = fv_q;
  assign frame_timeout = ft_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Directed bench for seg_display_capture: frames, invalid digit, short holds,
// timeout, mid-frame reset and a single-cycle glitch.
module tb_seg_display_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_timeout;

  int errors = 0;
  int checks = 0;
  int fv_cnt = 0;
  int ft_cnt = 0;
  int viol   = 0;
  int fv0, ft0;
  logic [19:0] last_out = '0;

  seg_display_capture #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg           (seg),
    .an            (an),
    .bcd_out       (bcd_out),
    .digit_err     (digit_err),
    .frame_valid   (frame_valid),
    .frame_timeout (frame_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters and a watch on outputs changing outside a frame_valid cycle.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (frame_timeout === 1'b1) ft_cnt++;
    if (rst_n === 1'b1 && frame_valid !== 1'b1 && {bcd_out, digit_err} !== last_out) viol++;
    last_out = {bcd_out, digit_err};
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int digit, input logic [6:0] s, input int n);
    step(4'(~(4'b0001 << digit)), s, n);
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3);
    show(0, pat(d0), 10);
    show(1, pat(d1), 10);
    show(2, pat(d2), 10);
    show(3, pat(d3), 10);
    step(4'hF, 7'h7F, 12);
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 32'h0000);
    check("rst_err", 32'(digit_err), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_ft", 32'(frame_timeout), 32'h0);
    rst_n = 1'b1;
    step(4'hF, 7'h7F, 4);

    // Basic frame 1,2,3,4
    fv0 = fv_cnt; ft0 = ft_cnt;
    scan(1, 2, 3, 4);
    check("f1_fv", 32'(fv_cnt - fv0), 32'd1);
    check("f1_bcd", 32'(bcd_out), 32'h4321);
    check("f1_err", 32'(digit_err), 32'h0);
    check("f1_ft", 32'(ft_cnt - ft0), 32'd0);

    // Digit 2 blank pattern with its enable asserted
    fv0 = fv_cnt;
    show(0, pat(5), 10);
    show(1, pat(6), 10);
    show(2, 7'b1111111, 10);
    show(3, pat(7), 10);
    step(4'hF, 7'h7F, 12);
    check("inv_fv", 32'(fv_cnt - fv0), 32'd1);
    check("inv_bcd", 32'(bcd_out), 32'h7F65);
    check("inv_err", 32'(digit_err), 32'b0100);

    // Holds one cycle short of stable, then two enables low together
    fv0 = fv_cnt; ft0 = ft_cnt;
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) show(d, pat(d + 1), 3);
    end
    step(4'b0011, pat(8), 20);
    step(4'hF, 7'h7F, 120);
    check("short_fv", 32'(fv_cnt - fv0), 32'd0);
    check("short_ft", 32'(ft_cnt - ft0), 32'd0);
    check("short_bcd", 32'(bcd_out), 32'h7F65);

    // Three digits only: frame abandoned after timeout
    fv0 = fv_cnt; ft0 = ft_cnt;
    show(0, pat(1), 10);
    show(1, pat(2), 10);
    show(2, pat(3), 10);
    step(4'hF, 7'h7F, 120);
    check("to_ft", 32'(ft_cnt - ft0), 32'd1);
    check("to_fv", 32'(fv_cnt - fv0), 32'd0);
    check("to_bcd", 32'(bcd_out), 32'h7F65);
    check("to_err", 32'(digit_err), 32'b0100);

    // Reset with two digits captured; partial frame must not surface later
    show(0, pat(9), 10);
    show(1, pat(8), 10);
    rst_n = 1'b0;
    step(4'hF, 7'h7F, 3);
    check("mrst_bcd", 32'(bcd_out), 32'h0000);
    check("mrst_err", 32'(digit_err), 32'h0);
    check("mrst_fv", 32'(frame_valid), 32'h0);
    rst_n = 1'b1;
    fv0 = fv_cnt; ft0 = ft_cnt;
    step(4'hF, 7'h7F, 120);
    check("mrst_nofv", 32'(fv_cnt - fv0), 32'd0);
    check("mrst_noft", 32'(ft_cnt - ft0), 32'd0);
    scan(9, 8, 7, 6);
    check("mrst_fv2", 32'(fv_cnt - fv0), 32'd1);
    check("mrst_bcd2", 32'(bcd_out), 32'h6789);
    check("mrst_err2", 32'(digit_err), 32'h0);

    // One-cycle glitch on digit 1 after three stable cycles
    fv0 = fv_cnt;
    show(0, pat(3), 10);
    show(1, pat(5), 3);
    show(1, pat(8), 1);
    show(1, pat(5), 10);
    show(2, pat(1), 10);
    show(3, pat(2), 10);
    step(4'hF, 7'h7F, 12);
    check("gl_fv", 32'(fv_cnt - fv0), 32'd1);
    check("gl_bcd", 32'(bcd_out), 32'h2153);
    check("gl_err", 32'(digit_err), 32'h0);

    check("out_hold", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
